axi_stream_bfm_core: RTL and testbench

- Synthesizable AXI-Stream traffic block with two independent halves.
  - Generator: a command-driven packet source on an AXI-Stream master port, with valid throttled to a programmable rate.
  - Sink: a consumer on an AXI-Stream slave port, with ready throttled to a programmable rate, plus beat/packet statistics and sequence checking.
- Used in testbenches and loopback self-test, in front of or behind stream interconnect under test.

---
 rtl/axi_stream_bfm_pkg.sv | 21 ++
 rtl/stream_rate_gate.sv | 30 +++
 rtl/axi_stream_bfm_core.sv | 168 ++++++++++++++++
 tb/tb_axi_stream_bfm_core.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_bfm_pkg.sv
// Shared constants, state type and LFSR step function for the stream BFM core.
package axi_stream_bfm_pkg;

    localparam int          LFSR_W       = 16;
    // Feedback taps x^16 + x^14 + x^13 + x^11 -> register bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] GEN_SEED_DEF = 16'hACE1;
    localparam logic [15:0] SNK_SEED_DEF = 16'h1D2B;
    localparam logic [7:0]  RATE_ALWAYS  = 8'd128;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } gen_state_e;

    // One Fibonacci shift: XOR of the tapped bits enters at the bottom
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/stream_rate_gate.sv
// Pseudo-random throttle: passes when the low LFSR bits fall below the rate.
module stream_rate_gate
    import axi_stream_bfm_pkg::*;
#(
    parameter logic [15:0] SEED = GEN_SEED_DEF
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       aclken,
    input  logic [7:0] rate,
    output logic       pass
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    assign lfsr_d = lfsr_next(lfsr_q);

    // LFSR advances once per enabled cycle, reloads its seed on reset
    always_ff @(posedge clock) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else if (aclken) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign pass = (rate >= RATE_ALWAYS) || (lfsr_q[6:0] < rate[6:0]);

endmodule

// File: rtl/axi_stream_bfm_core.sv
// AXI-Stream traffic block: throttled packet generator plus throttled checking sink.
module axi_stream_bfm_core
    import axi_stream_bfm_pkg::*;
#(
    parameter int          DSIZE    = 8,
    parameter int          LEN_W    = 16,
    parameter logic [15:0] GEN_SEED = GEN_SEED_DEF,
    parameter logic [15:0] SNK_SEED = SNK_SEED_DEF
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             aclken,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [DSIZE-1:0] cmd_base,
    input  logic [7:0]       cmd_rate,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [DSIZE-1:0] m_tdata,
    output logic             m_tlast,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [DSIZE-1:0] s_tdata,
    input  logic             s_tlast,
    input  logic             snk_en,
    input  logic [7:0]       snk_rate,
    output logic [31:0]      stat_beats,
    output logic [31:0]      stat_pkts,
    output logic [DSIZE-1:0] last_data,
    output logic             err_seq
);

    gen_state_e       state_q;
    logic             cmd_ready_q;
    logic             m_tvalid_q;
    logic [DSIZE-1:0] m_tdata_q;
    logic             m_tlast_q;
    logic [LEN_W-1:0] len_q;
    logic [DSIZE-1:0] base_q;
    logic [7:0]       rate_q;
    logic [LEN_W-1:0] idx_q;

    logic             s_tready_q;
    logic [31:0]      beats_q;
    logic [31:0]      pkts_q;
    logic [DSIZE-1:0] last_data_q;
    logic             err_q;
    logic             first_q;

    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] idx_nx;
    logic [7:0]       gen_rate;
    logic             gen_pass;
    logic             snk_pass;

    assign len_eff  = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
    assign idx_nx   = idx_q + LEN_W'(1);
    // While idle the gate looks at the incoming command so the first beat can rise on accept
    assign gen_rate = (state_q == IDLE) ? cmd_rate : rate_q;

    stream_rate_gate #(.SEED(GEN_SEED)) u_gen_gate (
        .clock (clock),
        .rst   (rst),
        .aclken(aclken),
        .rate  (gen_rate),
        .pass  (gen_pass)
    );

    stream_rate_gate #(.SEED(SNK_SEED)) u_snk_gate (
        .clock (clock),
        .rst   (rst),
        .aclken(aclken),
        .rate  (snk_rate),
        .pass  (snk_pass)
    );

    // Generator FSM: idx_q is the index of the beat being presented or about to be
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            m_tvalid_q  <= 1'b0;
            m_tdata_q   <= '0;
            m_tlast_q   <= 1'b0;
            len_q       <= '0;
            base_q      <= '0;
            rate_q      <= '0;
            idx_q       <= '0;
        end else if (aclken) begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        len_q       <= len_eff;
                        base_q      <= cmd_base;
                        rate_q      <= cmd_rate;
                        idx_q       <= '0;
                        state_q     <= RUN;
                        cmd_ready_q <= 1'b0;
                        if (gen_pass) begin
                            m_tvalid_q <= 1'b1;
                            m_tdata_q  <= cmd_base;
                            m_tlast_q  <= (len_eff == LEN_W'(1));
                        end
                    end
                end
                RUN: begin
                    if (!m_tvalid_q) begin
                        if (gen_pass) begin
                            m_tvalid_q <= 1'b1;
                            m_tdata_q  <= base_q + DSIZE'(idx_q);
                            m_tlast_q  <= (idx_q == len_q - LEN_W'(1));
                        end
                    end else if (m_tready) begin
                        if (m_tlast_q) begin
                            state_q     <= IDLE;
                            m_tvalid_q  <= 1'b0;
                            m_tlast_q   <= 1'b0;
                            cmd_ready_q <= 1'b1;
                        end else begin
                            idx_q      <= idx_nx;
                            m_tvalid_q <= gen_pass;
                            if (gen_pass) begin
                                m_tdata_q <= base_q + DSIZE'(idx_nx);
                                m_tlast_q <= (idx_nx == len_q - LEN_W'(1));
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Sink: registered throttled ready, statistics and sticky sequence check
    always_ff @(posedge clock) begin
        if (rst) begin
            s_tready_q  <= 1'b0;
            beats_q     <= '0;
            pkts_q      <= '0;
            last_data_q <= '0;
            err_q       <= 1'b0;
            first_q     <= 1'b1;
        end else if (aclken) begin
            s_tready_q <= snk_en && snk_pass;
            if (s_tvalid && s_tready_q) begin
                beats_q     <= beats_q + 32'd1;
                pkts_q      <= pkts_q + (s_tlast ? 32'd1 : 32'd0);
                last_data_q <= s_tdata;
                first_q     <= s_tlast;
                if (!first_q && (s_tdata != last_data_q + DSIZE'(1))) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign m_tvalid   = m_tvalid_q;
    assign m_tdata    = m_tdata_q;
    assign m_tlast    = m_tlast_q;
    assign s_tready   = s_tready_q;
    assign stat_beats = beats_q;
    assign stat_pkts  = pkts_q;
    assign last_data  = last_data_q;
    assign err_seq    = err_q;

endmodule

// File: tb/tb_axi_stream_bfm_core.sv
// Directed bench for axi_stream_bfm_core: loopback, wrap, stalls, rate 0, sequence error, random rates.
module tb_axi_stream_bfm_core;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        aclken = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_len = '0;
    logic [7:0]  cmd_base = '0;
    logic [7:0]  cmd_rate = '0;
    logic        m_tvalid;
    logic        m_tready;
    logic [7:0]  m_tdata;
    logic        m_tlast;
    logic        s_tvalid;
    logic        s_tready;
    logic [7:0]  s_tdata;
    logic        s_tlast;
    logic        snk_en = 1'b0;
    logic [7:0]  snk_rate = '0;
    logic [31:0] stat_beats;
    logic [31:0] stat_pkts;
    logic [7:0]  last_data;
    logic        err_seq;

    logic        loop = 1'b1;
    logic        drv_tvalid = 1'b0;
    logic [7:0]  drv_tdata = '0;
    logic        drv_tlast = 1'b0;

    int checks = 0;
    int errors = 0;

    assign s_tvalid = loop ? m_tvalid : drv_tvalid;
    assign s_tdata  = loop ? m_tdata  : drv_tdata;
    assign s_tlast  = loop ? m_tlast  : drv_tlast;
    assign m_tready = loop ? s_tready : 1'b0;

    axi_stream_bfm_core #(.DSIZE(8), .LEN_W(16)) dut (
        .clock(clock), .rst(rst), .aclken(aclken),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_base(cmd_base), .cmd_rate(cmd_rate),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .snk_en(snk_en), .snk_rate(snk_rate),
        .stat_beats(stat_beats), .stat_pkts(stat_pkts),
        .last_data(last_data), .err_seq(err_seq)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_cmd(input logic [15:0] len, input logic [7:0] base, input logic [7:0] rate);
        cmd_len   = len;
        cmd_base  = base;
        cmd_rate  = rate;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drive_beat(input logic [7:0] d, input logic l);
        drv_tvalid = 1'b1;
        drv_tdata  = d;
        drv_tlast  = l;
        tick();
        drv_tvalid = 1'b0;
    endtask

    initial begin
        logic        hold_ok;
        logic        done;
        int          budget;
        int          lenv;
        logic [31:0] exp_beats;

        // Reset state
        do_reset();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_beats", stat_beats, 0);
        check("rst_pkts", stat_pkts, 0);
        check("rst_err", err_seq, 0);

        // Loopback, len 4 base 5, full rate
        snk_en   = 1'b1;
        snk_rate = 8'd128;
        tick();
        check("snk_ready_up", s_tready, 1);
        send_cmd(16'd4, 8'd5, 8'd128);
        check("lb_v0", m_tvalid, 1);
        check("lb_d0", m_tdata, 5);
        check("lb_l0", m_tlast, 0);
        check("lb_cmd_busy", cmd_ready, 0);
        tick();
        check("lb_d1", m_tdata, 6);
        check("lb_l1", m_tlast, 0);
        tick();
        check("lb_d2", m_tdata, 7);
        tick();
        check("lb_d3", m_tdata, 8);
        check("lb_l3", m_tlast, 1);
        tick();
        check("lb_done_v", m_tvalid, 0);
        check("lb_done_rdy", cmd_ready, 1);
        check("lb_beats", stat_beats, 4);
        check("lb_pkts", stat_pkts, 1);
        check("lb_last", last_data, 8);
        check("lb_err", err_seq, 0);

        // Data wrap FE, FF, 00
        send_cmd(16'd3, 8'hFE, 8'd128);
        check("wr_d0", m_tdata, 8'hFE);
        tick();
        check("wr_d1", m_tdata, 8'hFF);
        tick();
        check("wr_d2", m_tdata, 8'h00);
        check("wr_l2", m_tlast, 1);
        tick();
        check("wr_beats", stat_beats, 7);
        check("wr_pkts", stat_pkts, 2);
        check("wr_last", last_data, 0);
        check("wr_err", err_seq, 0);

        // Clock enable low freezes everything
        send_cmd(16'd2, 8'h30, 8'd128);
        aclken = 1'b0;
        repeat (3) tick();
        check("ce_v", m_tvalid, 1);
        check("ce_d", m_tdata, 8'h30);
        check("ce_rdy", s_tready, 1);
        check("ce_beats", stat_beats, 7);
        aclken = 1'b1;
        tick();
        check("ce_d1", m_tdata, 8'h31);
        tick();
        check("ce_beats_end", stat_beats, 9);
        check("ce_pkts_end", stat_pkts, 3);

        // Backpressure: beat 0 goes through, beat 1 stalls for 20 cycles
        send_cmd(16'd3, 8'h10, 8'd128);
        snk_en = 1'b0;
        tick();
        check("bp_d1", m_tdata, 8'h11);
        check("bp_rdy", s_tready, 0);
        hold_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!(m_tvalid === 1'b1 && m_tdata === 8'h11)) hold_ok = 1'b0;
        end
        check("bp_hold", hold_ok, 1);
        check("bp_beats_stall", stat_beats, 10);
        snk_en = 1'b1;
        tick();
        check("bp_d1_again", m_tdata, 8'h11);
        tick();
        check("bp_d2", m_tdata, 8'h12);
        check("bp_l2", m_tlast, 1);
        tick();
        check("bp_beats", stat_beats, 12);
        check("bp_pkts", stat_pkts, 4);
        check("bp_last", last_data, 8'h12);
        check("bp_err", err_seq, 0);

        // Rate 0 never presents a beat; reset recovers
        send_cmd(16'd2, 8'h40, 8'd0);
        hold_ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (m_tvalid !== 1'b0 || cmd_ready !== 1'b0) hold_ok = 1'b0;
            tick();
        end
        check("r0_stuck", hold_ok, 1);
        do_reset();
        check("r0_rst_rdy", cmd_ready, 1);
        check("r0_rst_v", m_tvalid, 0);
        check("r0_rst_beats", stat_beats, 0);

        // Sequence checking with the slave driven directly
        loop     = 1'b0;
        snk_en   = 1'b1;
        snk_rate = 8'd128;
        tick();
        drive_beat(8'd3, 1'b0);
        drive_beat(8'd4, 1'b0);
        drive_beat(8'd5, 1'b1);
        drive_beat(8'd20, 1'b0);
        drive_beat(8'd21, 1'b1);
        check("sq_good_err", err_seq, 0);
        check("sq_good_pkts", stat_pkts, 2);
        drive_beat(8'd3, 1'b0);
        drive_beat(8'd4, 1'b0);
        check("sq_pre_err", err_seq, 0);
        drive_beat(8'd9, 1'b1);
        check("sq_err", err_seq, 1);
        check("sq_beats", stat_beats, 8);
        check("sq_pkts", stat_pkts, 3);
        check("sq_last", last_data, 9);
        drive_beat(8'd1, 1'b0);
        drive_beat(8'd2, 1'b1);
        check("sq_sticky", err_seq, 1);
        do_reset();
        check("sq_rst_err", err_seq, 0);

        // Random rates, loopback
        loop      = 1'b1;
        exp_beats = 0;
        done      = 1'b1;
        for (int p = 0; p < 200 && done; p++) begin
            budget = 0;
            while (cmd_ready !== 1'b1 && budget < 5000) begin
                tick();
                budget++;
            end
            if (cmd_ready !== 1'b1) begin
                done = 1'b0;
            end else begin
                lenv      = (p == 0) ? 0 : $urandom_range(41, 1);
                exp_beats = exp_beats + ((lenv == 0) ? 32'd1 : 32'(lenv));
                snk_rate  = 8'($urandom_range(100, 10));
                send_cmd(16'(lenv), 8'($urandom_range(255, 0)), 8'($urandom_range(100, 10)));
            end
        end
        budget = 0;
        while (done && cmd_ready !== 1'b1 && budget < 5000) begin
            tick();
            budget++;
        end
        check("rnd_no_timeout", {31'd0, done && cmd_ready === 1'b1}, 1);
        check("rnd_pkts", stat_pkts, 200);
        check("rnd_beats", stat_beats, exp_beats);
        check("rnd_err", err_seq, 0);
        check("rnd_idle_v", m_tvalid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
